// File: rtl/fpu_issue_sequencer.sv
// fpu_issue_sequencer: request FIFO plus single-in-flight issue stage in front
// of the FPU core. Requests are queued, issued with a one-cycle start pulse,
// and the core result is held on a valid/ready response port.
// Optional feature: define FPU_ISSUE_TIMEOUT_EN to bound the WAIT state by
// TIMEOUT cycles and force a qNaN completion with a sticky timeout_o.
module fpu_issue_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [31:0]                req_opa_i,
   input  logic [31:0]                req_opb_i,
   input  logic [2:0]                 req_op_i,
   input  logic [1:0]                 req_rmode_i,
   input  logic [TAG_W-1:0]           req_tag_i,
   output logic                       fpu_start_o,
   output logic [31:0]                fpu_opa_o,
   output logic [31:0]                fpu_opb_o,
   output logic [2:0]                 fpu_op_o,
   output logic [1:0]                 fpu_rmode_o,
   input  logic                       fpu_ready_i,
   input  logic [31:0]                fpu_result_i,
   input  logic [4:0]                 fpu_flags_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [31:0]                rsp_result_o,
   output logic [4:0]                 rsp_flags_o,
   output logic [TAG_W-1:0]           rsp_tag_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       timeout_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH+1);
   localparam int unsigned EW = 32 + 32 + 3 + 2 + TAG_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [EW-1:0]     mem_q [DEPTH];
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [LW-1:0]     level_q, level_d;
   logic [EW-1:0]     head;
   logic              push, pop, capture, expire, release_rsp;
   logic [31:0]       fpu_opa_q, fpu_opb_q;
   logic [2:0]        fpu_op_q;
   logic [1:0]        fpu_rmode_q;
   logic [TAG_W-1:0]  tag_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_result_q;
   logic [4:0]        rsp_flags_q;
   logic [TAG_W-1:0]  rsp_tag_q;

   // Ready comes from registered occupancy only, so a full FIFO never refills
   // in the same cycle it pops; held low while reset is asserted.
   assign req_ready_o = ~rst_i & (level_q != LW'(DEPTH));
   assign push        = req_valid_i & req_ready_o;
   assign pop         = (state_q == S_IDLE) & (level_q != '0);
   assign capture     = (state_q == S_WAIT) & fpu_ready_i;
   assign release_rsp = (state_q == S_HOLD) & rsp_ready_i;
   assign head        = mem_q[rptr_q];

`ifdef FPU_ISSUE_TIMEOUT_EN
   localparam int unsigned CW = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;
   logic [CW-1:0] cnt_q;
   logic          timeout_q;

   // A core completion on the terminal count wins over the forced timeout.
   assign expire    = (state_q == S_WAIT) & ~fpu_ready_i & (cnt_q == CW'(TIMEOUT-1));
   assign timeout_o = timeout_q;

   // WAIT cycle counter and sticky timeout flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == S_ISSUE) begin
            cnt_q <= '0;
         end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (expire) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   assign expire    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // Next-state and occupancy logic.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      unique case (state_q)
         S_IDLE:  if (pop) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (capture || expire) state_d = S_HOLD;
         S_HOLD:  if (release_rsp) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q] <= {req_opa_i, req_opb_i, req_op_i, req_rmode_i, req_tag_i};
      end
   end

   // State, pointers and the issue registers loaded from the FIFO head.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         level_q     <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         fpu_opa_q   <= '0;
         fpu_opb_q   <= '0;
         fpu_op_q    <= '0;
         fpu_rmode_q <= '0;
         tag_q       <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         if (push) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
            {fpu_opa_q, fpu_opb_q, fpu_op_q, fpu_rmode_q, tag_q} <= head;
         end
      end
   end

   // Response registers: captured on completion, held until accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_tag_q    <= '0;
      end else begin
         if (capture) begin
            rsp_result_q <= fpu_result_i;
            rsp_flags_q  <= fpu_flags_i;
            rsp_tag_q    <= tag_q;
         end else if (expire) begin
            rsp_result_q <= 32'h7FC0_0000;
            rsp_flags_q  <= 5'b00001;
            rsp_tag_q    <= tag_q;
         end
         if (capture || expire) begin
            rsp_valid_q <= 1'b1;
         end else if (release_rsp) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign fpu_start_o  = (state_q == S_ISSUE);
   assign fpu_opa_o    = fpu_opa_q;
   assign fpu_opb_o    = fpu_opb_q;
   assign fpu_op_o     = fpu_op_q;
   assign fpu_rmode_o  = fpu_rmode_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_flags_o  = rsp_flags_q;
   assign rsp_tag_o    = rsp_tag_q;
   assign level_o      = level_q;

endmodule
